// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct constants and latency encodings for the ID/EX boundary.
// The EX decoder imports the same package so both stages agree on the encodings.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_RA   = 5'd31;
  localparam logic [31:0] LINK_OFS = 32'd8;
  localparam logic [15:0] BCNT_MAX = 16'hFFFF;

  // Cycles until the EX-stage instruction produces its result.
  typedef enum logic [1:0] {
    TNEW_NONE = 2'd0,
    TNEW_ONE  = 2'd1,
    TNEW_TWO  = 2'd2
  } tnew_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] ext_imm;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic        valid;
  } ex_stage_t;

  function automatic logic [5:0] op_of(input logic [31:0] ins);
    return ins[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] ins);
    return ins[5:0];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] ins);
    return ins[20:16];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] ins);
    return ins[15:11];
  endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline boundary bundle: ID-side operands in, EX-side latched values out.
// master = ID stage / hazard unit side, slave = the pipeline register.
interface id_ex_reg_if;

  logic        stall;
  logic [31:0] ins_d;
  logic [31:0] pc_d;
  logic [31:0] rs_data_d;
  logic [31:0] rt_data_d;
  logic [31:0] ext_imm_d;

  logic [31:0] ins_e;
  logic [31:0] pc_e;
  logic [31:0] pc8_e;
  logic [31:0] rs_data_e;
  logic [31:0] rt_data_e;
  logic [31:0] ext_imm_e;
  logic [4:0]  a3_e;
  logic [1:0]  tnew_e;
  logic        valid_e;
  logic [15:0] bubble_cnt;

  modport master (
    output stall, ins_d, pc_d, rs_data_d, rt_data_d, ext_imm_d,
    input  ins_e, pc_e, pc8_e, rs_data_e, rt_data_e, ext_imm_e,
    input  a3_e, tnew_e, valid_e, bubble_cnt
  );

  modport slave (
    input  stall, ins_d, pc_d, rs_data_d, rt_data_d, ext_imm_d,
    output ins_e, pc_e, pc8_e, rs_data_e, rt_data_e, ext_imm_e,
    output a3_e, tnew_e, valid_e, bubble_cnt
  );

endinterface

// File: rtl/id_ex_dest_decode.sv
// Combinational decode of destination register and result latency for an ID instruction.
// Anything not explicitly writing a GPR (sw, beq, j, jr, nop, unknown) reports a3=0, tnew=0.
module id_ex_dest_decode
  import mips_defs::*;
(
  input  logic [31:0] i_ins,
  output logic [4:0]  o_a3,
  output logic [1:0]  o_tnew
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  tnew_t      w_tnew;
  logic       w_unused;

  assign w_op     = op_of(i_ins);
  assign w_funct  = funct_of(i_ins);
  assign w_unused = ^{i_ins[25:21], i_ins[10:6]};

  always_comb begin
    o_a3   = REG_ZERO;
    w_tnew = TNEW_NONE;
    case (w_op)
      OP_RTYPE: begin
        if (w_funct == FN_ADDU || w_funct == FN_SUBU) begin
          o_a3   = rd_of(i_ins);
          w_tnew = TNEW_ONE;
        end
      end
      OP_ORI, OP_LUI: begin
        o_a3   = rt_of(i_ins);
        w_tnew = TNEW_ONE;
      end
      OP_LW: begin
        o_a3   = rt_of(i_ins);
        w_tnew = TNEW_TWO;
      end
      OP_JAL: begin
        o_a3   = REG_RA;
        w_tnew = TNEW_NONE;
      end
      default: begin
        o_a3   = REG_ZERO;
        w_tnew = TNEW_NONE;
      end
    endcase
  end

  assign o_tnew = w_tnew;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: loads ID values each edge, or a zeroed bubble while stalled.
// Also keeps a saturating count of inserted bubbles for performance visibility.
module id_ex_reg
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  id_ex_reg_if.slave  bus
);

  ex_stage_t   r_ex;
  logic [15:0] r_bubble_cnt;
  logic [4:0]  w_a3;
  logic [1:0]  w_tnew;

  id_ex_dest_decode u_dest_decode (
    .i_ins  (bus.ins_d),
    .o_a3   (w_a3),
    .o_tnew (w_tnew)
  );

  // Reset wins over stall, so a reset during a stall leaves the count at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex         <= '0;
      r_bubble_cnt <= '0;
    end else if (bus.stall) begin
      r_ex <= '0;
      if (r_bubble_cnt != BCNT_MAX) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end else begin
      r_ex.ins     <= bus.ins_d;
      r_ex.pc      <= bus.pc_d;
      r_ex.rs_data <= bus.rs_data_d;
      r_ex.rt_data <= bus.rt_data_d;
      r_ex.ext_imm <= bus.ext_imm_d;
      r_ex.a3      <= w_a3;
      r_ex.tnew    <= w_tnew;
      r_ex.valid   <= 1'b1;
    end
  end

  assign bus.ins_e      = r_ex.ins;
  assign bus.pc_e       = r_ex.pc;
  assign bus.pc8_e      = r_ex.pc + LINK_OFS;
  assign bus.rs_data_e  = r_ex.rs_data;
  assign bus.rt_data_e  = r_ex.rt_data;
  assign bus.ext_imm_e  = r_ex.ext_imm;
  assign bus.a3_e       = r_ex.a3;
  assign bus.tnew_e     = r_ex.tnew;
  assign bus.valid_e    = r_ex.valid;
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: each driven cycle pushes the modelled EX state,
// which is popped and compared one edge later.
module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic        valid;
    logic [15:0] bcnt;
  } obs_t;

  logic clk;
  logic reset;
  obs_t sb[$];
  obs_t exp_v;
  obs_t obs_v;
  int   n_pass;
  int   n_total;
  logic [15:0] m_bcnt;

  id_ex_reg_if bus ();

  id_ex_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference decode: {a3, tnew}
  function automatic logic [6:0] ref_dest(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) return {ins[15:11], 2'd1};
    if (op == 6'h0D || op == 6'h0F) return {ins[20:16], 2'd1};
    if (op == 6'h23) return {ins[20:16], 2'd2};
    if (op == 6'h03) return {5'd31, 2'd0};
    return 7'd0;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.ins   = bus.ins_e;
    o.pc    = bus.pc_e;
    o.pc8   = bus.pc8_e;
    o.rs    = bus.rs_data_e;
    o.rt    = bus.rt_data_e;
    o.imm   = bus.ext_imm_e;
    o.a3    = bus.a3_e;
    o.tnew  = bus.tnew_e;
    o.valid = bus.valid_e;
    o.bcnt  = bus.bubble_cnt;
    return o;
  endfunction

  task automatic drive(input logic rst, input logic stl, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] imm);
    obs_t e;
    logic [6:0] d;
    reset         = rst;
    bus.stall     = stl;
    bus.ins_d     = ins;
    bus.pc_d      = pc;
    bus.rs_data_d = rs;
    bus.rt_data_d = rt;
    bus.ext_imm_d = imm;
    e = '0;
    if (rst) begin
      m_bcnt = 16'd0;
    end else if (stl) begin
      if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
    end else begin
      d       = ref_dest(ins);
      e.ins   = ins;
      e.pc    = pc;
      e.rs    = rs;
      e.rt    = rt;
      e.imm   = imm;
      e.a3    = d[6:2];
      e.tnew  = d[1:0];
      e.valid = 1'b1;
    end
    e.pc8  = e.pc + 32'd8;
    e.bcnt = m_bcnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h1234, 32'h1, 32'h2, 32'h3);
    exp_v = sb.pop_front();
    obs_v = observe();
    n_total++;
    if (obs_v !== exp_v) $display("FAIL reset_state got=%h exp=%h", obs_v, exp_v);
    else n_pass++;
    n_total++;
    if (bus.pc8_e !== 32'd8 || bus.bubble_cnt !== 16'd0)
      $display("FAIL reset_pc8 got pc8=%h bcnt=%h exp pc8=8 bcnt=0", bus.pc8_e, bus.bubble_cnt);
    else n_pass++;
  endtask

  task automatic test_addu();
    drive(1'b0, 1'b0, 32'h00851021, 32'h00003000, 32'h11, 32'h22, 32'h33);
    exp_v = sb.pop_front();
    obs_v = observe();
    n_total++;
    if (obs_v !== exp_v) $display("FAIL addu got=%h exp=%h", obs_v, exp_v);
    else n_pass++;
    n_total++;
    if (bus.a3_e !== 5'd2 || bus.tnew_e !== 2'd1 || bus.pc8_e !== 32'h00003008)
      $display("FAIL addu_fields got a3=%0d tnew=%0d pc8=%h exp a3=2 tnew=1 pc8=00003008",
               bus.a3_e, bus.tnew_e, bus.pc8_e);
    else n_pass++;
  endtask

  task automatic test_lw_stall();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    void'(sb.pop_front());
    drive(1'b0, 1'b0, 32'h8C880004, 32'h00003004, 32'hA, 32'hB, 32'h4);
    exp_v = sb.pop_front();
    obs_v = observe();
    n_total++;
    if (obs_v !== exp_v) $display("FAIL lw_capture got=%h exp=%h", obs_v, exp_v);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h8C880004, 32'h00003008, 32'hA, 32'hB, 32'h4);
      exp_v = sb.pop_front();
      obs_v = observe();
      n_total++;
      if (obs_v !== exp_v) $display("FAIL lw_bubble%0d got=%h exp=%h", i, obs_v, exp_v);
      else n_pass++;
    end
    n_total++;
    if (bus.bubble_cnt !== 16'd3) $display("FAIL bubble_cnt3 got=%0d exp=3", bus.bubble_cnt);
    else n_pass++;
  endtask

  task automatic test_jal_wrap();
    drive(1'b0, 1'b0, 32'h0C000C00, 32'hFFFFFFF8, 32'h5, 32'h6, 32'h7);
    exp_v = sb.pop_front();
    obs_v = observe();
    n_total++;
    if (obs_v !== exp_v) $display("FAIL jal got=%h exp=%h", obs_v, exp_v);
    else n_pass++;
    n_total++;
    if (bus.a3_e !== 5'd31 || bus.pc8_e !== 32'h0)
      $display("FAIL jal_wrap got a3=%0d pc8=%h exp a3=31 pc8=00000000", bus.a3_e, bus.pc8_e);
    else n_pass++;
  endtask

  task automatic test_sw_nop_misc();
    logic [31:0] tbl [6];
    tbl[0] = 32'hAC090000;  // sw
    tbl[1] = 32'h00000000;  // nop
    tbl[2] = 32'h3C0A1234;  // lui rt=10
    tbl[3] = 32'h354B00FF;  // ori rt=11
    tbl[4] = 32'h00A66023;  // subu rd=12
    tbl[5] = 32'h10850003;  // beq
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, tbl[i], 32'h4000 + 32'(i * 4), 32'h100 + 32'(i),
            32'hCAFE0000 + 32'(i), 32'h0000FFFF);
      exp_v = sb.pop_front();
      obs_v = observe();
      n_total++;
      if (obs_v !== exp_v) $display("FAIL misc%0d got=%h exp=%h", i, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops [8];
    logic [5:0]  fns [4];
    logic [31:0] ins;
    ops[0] = 6'h00; ops[1] = 6'h0D; ops[2] = 6'h0F; ops[3] = 6'h23;
    ops[4] = 6'h2B; ops[5] = 6'h03; ops[6] = 6'h04; ops[7] = 6'h02;
    fns[0] = 6'h21; fns[1] = 6'h23; fns[2] = 6'h08; fns[3] = 6'h2A;
    for (int i = 0; i < 40; i++) begin
      ins = {ops[$urandom_range(7)], 26'($urandom)};
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(3)];
      drive(1'b0, ($urandom_range(3) == 0), ins, $urandom, $urandom, $urandom, $urandom);
      exp_v = sb.pop_front();
      obs_v = observe();
      n_total++;
      if (obs_v !== exp_v) $display("FAIL b2b%0d got=%h exp=%h", i, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_over_stall_and_saturate();
    drive(1'b1, 1'b1, 32'h00851021, 32'h10, 32'h1, 32'h2, 32'h3);
    exp_v = sb.pop_front();
    obs_v = observe();
    n_total++;
    if (obs_v !== exp_v) $display("FAIL reset_stall got=%h exp=%h", obs_v, exp_v);
    else n_pass++;
    for (int i = 0; i < 65540; i++) begin
      drive(1'b0, 1'b1, 32'h00851021, 32'h10, 32'h1, 32'h2, 32'h3);
      exp_v = sb.pop_front();
      obs_v = observe();
      n_total++;
      if (obs_v !== exp_v) $display("FAIL sat%0d got=%h exp=%h", i, obs_v, exp_v);
      else n_pass++;
    end
    n_total++;
    if (bus.bubble_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", bus.bubble_cnt);
    else n_pass++;
    drive(1'b0, 1'b0, 32'h8C880004, 32'h20, 32'h1, 32'h2, 32'h3);
    exp_v = sb.pop_front();
    obs_v = observe();
    n_total++;
    if (obs_v !== exp_v) $display("FAIL after_sat got=%h exp=%h", obs_v, exp_v);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_bcnt  = 16'd0;
    reset   = 1'b1;
    bus.stall     = 1'b0;
    bus.ins_d     = '0;
    bus.pc_d      = '0;
    bus.rs_data_d = '0;
    bus.rt_data_d = '0;
    bus.ext_imm_d = '0;
    test_reset();
    test_addu();
    test_lw_stall();
    test_jal_wrap();
    test_sw_nop_misc();
    test_back_to_back();
    test_reset_over_stall_and_saturate();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drain got=%0d exp=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
